// File: rtl/coherent_bus_controller.sv
// Multi-CPU coherent memory controller: round-robin arbitration of icache/dcache requests onto one RAM port.
// Optional abort of stalled RAM accesses is enabled by defining CC_TIMEOUT_EN.
module coherent_bus_controller #(
    parameter int CPUS           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [CPUS-1:0]        iREN,
    input  logic [32*CPUS-1:0]     iaddr,
    input  logic [CPUS-1:0]        dREN,
    input  logic [CPUS-1:0]        dWEN,
    input  logic [32*CPUS-1:0]     daddr,
    input  logic [32*CPUS-1:0]     dstore,
    input  logic [CPUS-1:0]        ccwrite,
    input  logic [CPUS-1:0]        cctrans,
    output logic [CPUS-1:0]        iwait,
    output logic [CPUS-1:0]        dwait,
    output logic [32*CPUS-1:0]     iload,
    output logic [32*CPUS-1:0]     dload,
    output logic [CPUS-1:0]        ccwait,
    output logic [CPUS-1:0]        ccinv,
    output logic [32*CPUS-1:0]     ccsnoopaddr,
    output logic                   ramREN,
    output logic                   ramWEN,
    output logic [31:0]            ramaddr,
    output logic [31:0]            ramstore,
    input  logic [31:0]            ramload,
    input  logic [1:0]             ramstate,
    output logic                   timeout
);

    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

    typedef enum logic [1:0] {RS_FREE, RS_BUSY, RS_ACCESS, RS_ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, SNOOP, MEM} state_t;

    state_t        state;
    logic [CW-1:0] rr;
    logic [CW-1:0] gcpu;
    logic          gdata;
    logic          gwrite;

    logic          win_found;
    logic [CW-1:0] win_cpu;
    logic          win_data;
    logic          win_write;
    logic          win_snoop;
    int            idx;

    logic          gactive;
    logic          done;

    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
        if (int'(v) >= CPUS - 1)
            return '0;
        else
            return v + 1'b1;
    endfunction

    assign iload = {CPUS{ramload}};
    assign dload = {CPUS{ramload}};

    // Round-robin scan from rr; a CPU's data request outranks its instruction fetch.
    always_comb begin
        win_found = 1'b0;
        win_cpu   = '0;
        win_data  = 1'b0;
        win_write = 1'b0;
        win_snoop = 1'b0;
        idx       = 0;
        for (int off = 0; off < CPUS; off++) begin
            idx = int'(rr) + off;
            if (idx >= CPUS)
                idx = idx - CPUS;
            if (!win_found && (iREN[idx] || dREN[idx] || dWEN[idx])) begin
                win_found = 1'b1;
                win_cpu   = idx[CW-1:0];
                win_data  = dREN[idx] || dWEN[idx];
                win_write = dWEN[idx];
                win_snoop = (dREN[idx] || dWEN[idx]) && cctrans[idx];
            end
        end
    end

    assign gactive = gdata ? (dREN[gcpu] || dWEN[gcpu]) : iREN[gcpu];
    assign done    = (state == MEM) && gactive && (ramstate == RS_ACCESS);

    always_comb begin
        iwait = '1;
        dwait = '1;
        if (done) begin
            if (gdata)
                dwait[gcpu] = 1'b0;
            else
                iwait[gcpu] = 1'b0;
        end
    end

    // Address and write data follow the granted requester live while in MEM.
    always_comb begin
        ramaddr  = '0;
        ramstore = '0;
        if (state == MEM) begin
            if (gdata) begin
                ramaddr = daddr[int'(gcpu)*32 +: 32];
                if (gwrite)
                    ramstore = dstore[int'(gcpu)*32 +: 32];
            end else begin
                ramaddr = iaddr[int'(gcpu)*32 +: 32];
            end
        end
    end

`ifdef CC_TIMEOUT_EN
    logic [31:0] tcount;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            rr          <= '0;
            gcpu        <= '0;
            gdata       <= 1'b0;
            gwrite      <= 1'b0;
            ccwait      <= '0;
            ccinv       <= '0;
            ccsnoopaddr <= '0;
            ramREN      <= 1'b0;
            ramWEN      <= 1'b0;
`ifdef CC_TIMEOUT_EN
            tcount      <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    ramREN <= 1'b0;
                    ramWEN <= 1'b0;
                    ccwait <= '0;
                    ccinv  <= '0;
`ifdef CC_TIMEOUT_EN
                    timeout <= 1'b0;
                    tcount  <= '0;
`endif
                    if (win_found) begin
                        gcpu   <= win_cpu;
                        gdata  <= win_data;
                        gwrite <= win_write;
                        if (win_snoop) begin
                            // Every other dcache sees the snoop for exactly one cycle.
                            state <= SNOOP;
                            for (int j = 0; j < CPUS; j++) begin
                                if (j != int'(win_cpu)) begin
                                    ccwait[j]                <= 1'b1;
                                    ccinv[j]                 <= ccwrite[win_cpu];
                                    ccsnoopaddr[j*32 +: 32]  <= daddr[int'(win_cpu)*32 +: 32];
                                end
                            end
                        end else begin
                            state  <= MEM;
                            ramREN <= !(win_data && win_write);
                            ramWEN <= win_data && win_write;
                        end
                    end
                end
                SNOOP: begin
                    ccwait <= '0;
                    ccinv  <= '0;
                    state  <= MEM;
                    ramREN <= !gwrite;
                    ramWEN <= gwrite;
                end
                MEM: begin
                    if (!gactive) begin
                        // Requester withdrew: abandon without advancing fairness.
                        state  <= IDLE;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                    end else if (ramstate == RS_ACCESS) begin
                        state  <= IDLE;
                        rr     <= wrap_inc(gcpu);
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
`ifdef CC_TIMEOUT_EN
                    end else if (tcount == 32'(TIMEOUT_CYCLES - 1)) begin
                        state   <= IDLE;
                        rr      <= wrap_inc(gcpu);
                        ramREN  <= 1'b0;
                        ramWEN  <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        tcount <= tcount + 32'd1;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    ramREN <= 1'b0;
                    ramWEN <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coherent_bus_controller.sv
// Directed testbench for coherent_bus_controller (CPUS=2); also covers CC_TIMEOUT_EN builds.
`timescale 1ns/1ps
module tb_coherent_bus_controller;

    localparam int CPUS = 2;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic                 CLK;
    logic                 RST;
    logic [CPUS-1:0]      iREN, dREN, dWEN, ccwrite, cctrans;
    logic [32*CPUS-1:0]   iaddr, daddr, dstore;
    logic [CPUS-1:0]      iwait, dwait, ccwait, ccinv;
    logic [32*CPUS-1:0]   iload, dload, ccsnoopaddr;
    logic                 ramREN, ramWEN, timeout;
    logic [31:0]          ramaddr, ramstore, ramload;
    logic [1:0]           ramstate;

    int totalChecks = 0;
    int passedChecks = 0;
    int errs;

    coherent_bus_controller #(.CPUS(CPUS), .TIMEOUT_CYCLES(8)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .ccwrite(ccwrite), .cctrans(cctrans),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .timeout(timeout)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        totalChecks++;
        if (got === exp)
            passedChecks++;
        else
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive one cycle's requests just after the edge, then wait to mid-cycle for sampling.
    task automatic applyStimulus(input logic [1:0] ir, input logic [1:0] dr,
                                 input logic [1:0] dw, input logic [1:0] rs);
        @(posedge CLK);
        #1;
        iREN     = ir;
        dREN     = dr;
        dWEN     = dw;
        ramstate = rs;
        @(negedge CLK);
    endtask

    task automatic holdCycle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic doReset();
        @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_iwait", 64'(iwait), 64'h3);
        checkOutput("rst_dwait", 64'(dwait), 64'h3);
        checkOutput("rst_ccwait", 64'(ccwait), 64'h0);
        checkOutput("rst_ccinv", 64'(ccinv), 64'h0);
        checkOutput("rst_snoopaddr", ccsnoopaddr, 64'h0);
        checkOutput("rst_ren_wen", {62'd0, ramREN, ramWEN}, 64'h0);
        checkOutput("rst_ramaddr", 64'(ramaddr), 64'h0);
        checkOutput("rst_timeout", 64'(timeout), 64'h0);
        RST = 1'b0;

        // Instruction fetch with BUSY/ERROR stalls before ACCESS
        iaddr[31:0] = 32'h100;
        applyStimulus(2'b01, 2'b00, 2'b00, BUSY);
        checkOutput("t1_idle_ren", 64'(ramREN), 64'h0);
        holdCycle();
        checkOutput("t1_c1_ren", 64'(ramREN), 64'h1);
        checkOutput("t1_c1_addr", 64'(ramaddr), 64'h100);
        checkOutput("t1_c1_iwait", 64'(iwait), 64'h3);
        applyStimulus(2'b01, 2'b00, 2'b00, ERROR);
        checkOutput("t1_c2_ren", 64'(ramREN), 64'h1);
        checkOutput("t1_c2_iwait", 64'(iwait), 64'h3);
        ramload = 32'hDEADBEEF;
        applyStimulus(2'b01, 2'b00, 2'b00, ACCESS);
        checkOutput("t1_c3_ren", 64'(ramREN), 64'h1);
        checkOutput("t1_c3_iwait", 64'(iwait), 64'h2);
        checkOutput("t1_c3_iload", 64'(iload[31:0]), 64'hDEADBEEF);
        checkOutput("t1_c3_dload1", 64'(dload[63:32]), 64'hDEADBEEF);
        checkOutput("t1_c3_dwait", 64'(dwait), 64'h3);
        applyStimulus(2'b00, 2'b00, 2'b00, FREE);
        checkOutput("t1_after_ren", 64'(ramREN), 64'h0);
        checkOutput("t1_after_iwait", 64'(iwait), 64'h3);

        // Round-robin alternation with both dcaches reading
        doReset();
        daddr = {32'h20, 32'h10};
        applyStimulus(2'b00, 2'b11, 2'b00, ACCESS);
        checkOutput("t2_idle0_dwait", 64'(dwait), 64'h3);
        holdCycle();
        checkOutput("t2_g0_dwait", 64'(dwait), 64'h2);
        checkOutput("t2_g0_addr", 64'(ramaddr), 64'h10);
        holdCycle();
        checkOutput("t2_idle1_dwait", 64'(dwait), 64'h3);
        checkOutput("t2_idle1_ren", 64'(ramREN), 64'h0);
        holdCycle();
        checkOutput("t2_g1_dwait", 64'(dwait), 64'h1);
        checkOutput("t2_g1_addr", 64'(ramaddr), 64'h20);
        holdCycle();
        checkOutput("t2_idle2_dwait", 64'(dwait), 64'h3);
        holdCycle();
        checkOutput("t2_g2_dwait", 64'(dwait), 64'h2);
        checkOutput("t2_g2_addr", 64'(ramaddr), 64'h10);
        applyStimulus(2'b00, 2'b00, 2'b00, FREE);

        // Snooped write from CPU1
        daddr[63:32] = 32'h200;
        dstore[63:32] = 32'h55;
        ccwrite = 2'b10;
        cctrans = 2'b10;
        applyStimulus(2'b00, 2'b00, 2'b10, BUSY);
        checkOutput("t3_idle_ccwait", 64'(ccwait), 64'h0);
        holdCycle();
        checkOutput("t3_snoop_ccwait", 64'(ccwait), 64'h1);
        checkOutput("t3_snoop_ccinv", 64'(ccinv), 64'h1);
        checkOutput("t3_snoop_addr", 64'(ccsnoopaddr[31:0]), 64'h200);
        checkOutput("t3_snoop_wen", 64'(ramWEN), 64'h0);
        checkOutput("t3_snoop_dwait", 64'(dwait), 64'h3);
        applyStimulus(2'b00, 2'b00, 2'b10, ACCESS);
        checkOutput("t3_mem_wen", 64'(ramWEN), 64'h1);
        checkOutput("t3_mem_ren", 64'(ramREN), 64'h0);
        checkOutput("t3_mem_addr", 64'(ramaddr), 64'h200);
        checkOutput("t3_mem_store", 64'(ramstore), 64'h55);
        checkOutput("t3_mem_dwait", 64'(dwait), 64'h1);
        checkOutput("t3_mem_ccwait", 64'(ccwait), 64'h0);
        ccwrite = 2'b00;
        cctrans = 2'b00;
        applyStimulus(2'b00, 2'b00, 2'b00, FREE);
        checkOutput("t3_after_wen", 64'(ramWEN), 64'h0);
        checkOutput("t3_snoop_hold", ccsnoopaddr, 64'h0000_0000_0000_0200);

        // Data beats instruction within CPU0
        daddr[31:0] = 32'h300;
        iaddr[31:0] = 32'h400;
        applyStimulus(2'b01, 2'b01, 2'b00, ACCESS);
        holdCycle();
        checkOutput("t4_d_dwait", 64'(dwait), 64'h2);
        checkOutput("t4_d_iwait", 64'(iwait), 64'h3);
        checkOutput("t4_d_addr", 64'(ramaddr), 64'h300);
        applyStimulus(2'b01, 2'b00, 2'b00, ACCESS);
        checkOutput("t4_idle_iwait", 64'(iwait), 64'h3);
        holdCycle();
        checkOutput("t4_i_iwait", 64'(iwait), 64'h2);
        checkOutput("t4_i_addr", 64'(ramaddr), 64'h400);
        checkOutput("t4_i_dwait", 64'(dwait), 64'h3);
        applyStimulus(2'b00, 2'b00, 2'b00, FREE);

        // Reset in MEM abandons the access and restarts arbitration at CPU0
        iaddr[63:32] = 32'h500;
        applyStimulus(2'b10, 2'b00, 2'b00, BUSY);
        holdCycle();
        checkOutput("t5_mem_ren", 64'(ramREN), 64'h1);
        checkOutput("t5_mem_addr", 64'(ramaddr), 64'h500);
        @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        iREN = 2'b11;
        ramstate = ACCESS;
        @(negedge CLK);
        checkOutput("t5_rst_enables", {62'd0, ramREN, ramWEN}, 64'h0);
        checkOutput("t5_rst_iwait", 64'(iwait), 64'h3);
        checkOutput("t5_rst_dwait", 64'(dwait), 64'h3);
        holdCycle();
        checkOutput("t5_regrant_iwait", 64'(iwait), 64'h2);
        checkOutput("t5_regrant_addr", 64'(ramaddr), 64'h400);
        applyStimulus(2'b00, 2'b00, 2'b00, FREE);

        // RAM stuck BUSY
        doReset();
        iaddr = {32'h700, 32'h600};
        applyStimulus(2'b11, 2'b00, 2'b00, BUSY);
        errs = 0;
`ifdef CC_TIMEOUT_EN
        repeat (8) begin
            holdCycle();
            if (ramREN !== 1'b1 || timeout !== 1'b0 || ramaddr !== 32'h600)
                errs++;
        end
        checkOutput("t6_busy_cycles", 64'(errs), 64'h0);
        holdCycle();
        checkOutput("t6_timeout_pulse", 64'(timeout), 64'h1);
        checkOutput("t6_timeout_ren", 64'(ramREN), 64'h0);
        checkOutput("t6_timeout_iwait", 64'(iwait), 64'h3);
        holdCycle();
        checkOutput("t6_next_addr", 64'(ramaddr), 64'h700);
        checkOutput("t6_next_ren", 64'(ramREN), 64'h1);
        checkOutput("t6_next_timeout", 64'(timeout), 64'h0);
        applyStimulus(2'b00, 2'b00, 2'b00, FREE);
        holdCycle();
`else
        repeat (120) begin
            holdCycle();
            if (ramREN !== 1'b1 || timeout !== 1'b0 || iwait !== 2'b11)
                errs++;
        end
        checkOutput("t6_stuck_cycles", 64'(errs), 64'h0);
        checkOutput("t6_stuck_addr", 64'(ramaddr), 64'h600);
        applyStimulus(2'b00, 2'b00, 2'b00, BUSY);
        checkOutput("t6_drop_ren_hold", 64'(ramREN), 64'h1);
        holdCycle();
        checkOutput("t6_drop_ren", 64'(ramREN), 64'h0);
        checkOutput("t6_drop_iwait", 64'(iwait), 64'h3);
        applyStimulus(2'b11, 2'b00, 2'b00, ACCESS);
        holdCycle();
        checkOutput("t6_rr_kept_iwait", 64'(iwait), 64'h2);
        applyStimulus(2'b00, 2'b00, 2'b00, FREE);
`endif

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
